// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Central stall/flush controller for the 5-stage pipeline. It drives the
// hold/clear enables of the pipeline registers. It also arbitrates load-use
// hazards, taken-branch redirects and a variable-latency data-memory
// handshake. On top of that it provides a debug halt/single-step, a sticky
// memory-timeout trap and a saturating stall-cycle counter.
//
// Parameters
//   MEM_TIMEOUT  max wait cycles on dmem_ready before trapping (>= 2)
//   CNT_W        width of stall_count
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   memreadE, rdE             EX-stage load flag and destination register
//   rs1D, rs2D                ID-stage source registers
//   isbranchtakenE            branch/jump resolved taken in EX
//   memreadM, memwriteM       MEM-stage data-memory access
//   dmem_ready                data memory completes the MEM access this cycle
//   halt_req, step_req        debug halt (level) and single-step (pulse)
//   stallF/D/E/M              hold PC / IF-ID / ID-EX / EX-MEM  (combinational)
//   flushD, flushE            bubble IF-ID / ID-EX              (combinational)
//   killW                     bubble into MEM-WB                (combinational)
//   halted                    core frozen by debug or trap      (registered)
//   mem_timeout               sticky memory-timeout trap        (registered)
//   stall_count               saturating count of stallF cycles (registered)
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memreadE,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             isbranchtakenE,
  input  logic             memreadM,
  input  logic             memwriteM,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             killW,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED, STEP} state_t;

  localparam int                WC_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t             r_state, w_state_nxt;
  logic [WC_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic               r_halted;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_stall_count;
  logic               w_memwait, w_loaduse;
  logic               w_freeze, w_advance, w_timeout_set;

  assign w_memwait = (memreadM | memwriteM) & ~dmem_ready;
  assign w_loaduse = memreadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

  // r_wait_cnt holds the number of wait cycles already spent before the
  // current one. The first stalled cycle happens in RUN/STEP, so the count
  // starts at 1 on entry to MEMWAIT. The trap then fires on the
  // MEM_TIMEOUT-th frozen cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_freeze       = 1'b0;
    w_advance      = 1'b0;
    w_timeout_set  = 1'b0;
    if (rst) begin
      case (r_state)
        RUN, STEP: begin
          if (w_memwait) begin
            w_freeze       = 1'b1;
            w_state_nxt    = MEMWAIT;
            w_wait_cnt_nxt = WC_W'(1);
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = (r_state == STEP || halt_req) ? HALTED : RUN;
          end
        end
        MEMWAIT: begin
          if (dmem_ready) begin
            w_advance   = 1'b1;
            w_state_nxt = halt_req ? HALTED : RUN;
          end else begin
            w_freeze = 1'b1;
            if (r_wait_cnt >= WC_LAST) begin
              w_timeout_set = 1'b1;
              w_state_nxt   = HALTED;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
            end
          end
        end
        HALTED: begin
          w_freeze = 1'b1;
          // A trapped core stays here until reset.
          if (!r_mem_timeout) begin
            if (step_req)       w_state_nxt = STEP;
            else if (!halt_req) w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // When the pipeline advances, a taken branch wins over a load-use stall.
  // The fetch redirect then proceeds, and the ID-EX flush covers both cases.
  // While reset is low, every stage is bubbled and nothing is held.
  assign stallF = w_freeze | (w_advance & ~isbranchtakenE & w_loaduse);
  assign stallD = stallF;
  assign stallE = w_freeze;
  assign stallM = w_freeze;
  assign killW  = w_freeze | ~rst;
  assign flushD = ~rst | (w_advance & isbranchtakenE);
  assign flushE = ~rst | (w_advance & (isbranchtakenE | w_loaduse));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_halted   <= (w_state_nxt == HALTED);
      if (w_timeout_set)
        r_mem_timeout <= 1'b1;
      if (stallF && r_stall_count != CNT_MAX)
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign halted      = r_halted;
  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Self-checking bench for pipeline_sequencer. The reference model tracks the
// core in plain terms: whether it is frozen by debug, whether it has trapped,
// how many cycles the current memory access has waited, and whether a single
// step is in flight. It derives the expected outputs from the pipeline rules.
// A directed pass walks the scenarios of interest. A randomized pass follows
// it.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          memreadE;
  logic [4:0]    rdE, rs1D, rs2D;
  logic          isbranchtakenE, memreadM, memwriteM, dmem_ready;
  logic          halt_req, step_req;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, killW;
  logic          halted, mem_timeout;
  logic [CW-1:0] stall_count;

  pipeline_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .memreadE(memreadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
    .isbranchtakenE(isbranchtakenE),
    .memreadM(memreadM), .memwriteM(memwriteM), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .step_req(step_req),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .killW(killW),
    .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_frozen;   // core held by debug halt or trap
  bit m_trap;
  bit m_stepping; // one step cycle is in progress
  int m_waited;   // cycles the current memory access has already waited
  int m_cnt;

  function automatic bit model_mem_stall();
    if (m_waited > 0) return !dmem_ready;
    return (memreadM | memwriteM) & !dmem_ready;
  endfunction

  // {stallF, stallD, stallE, stallM, flushD, flushE, killW}
  function automatic logic [6:0] model_comb();
    if (!rst)                return 7'b0000_111;
    if (m_frozen)            return 7'b1111_001;
    if (model_mem_stall())   return 7'b1111_001;
    if (isbranchtakenE)      return 7'b0000_110;
    if (memreadE && rdE != 0 && (rdE == rs1D || rdE == rs2D))
                             return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  task automatic model_reset();
    m_frozen = 0; m_trap = 0; m_stepping = 0; m_waited = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic [6:0] e);
    if (!rst) begin
      model_reset();
    end else begin
      if (e[6] && m_cnt < CNT_SAT) m_cnt++;
      if (m_frozen) begin
        if (!m_trap) begin
          if (step_req) begin m_frozen = 0; m_stepping = 1; end
          else if (!halt_req) m_frozen = 0;
        end
      end else if (model_mem_stall()) begin
        m_stepping = 0;
        m_waited++;
        if (m_waited >= MT) begin m_trap = 1; m_frozen = 1; m_waited = 0; end
      end else begin
        if (m_stepping) begin m_frozen = 1; m_stepping = 0; end
        else m_frozen = halt_req;
        m_waited = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic r, input logic mre, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2, input logic br,
                        input logic mrm, input logic mwm, input logic rdy,
                        input logic hr, input logic sr);
    rst = r; memreadE = mre; rdE = rd; rs1D = s1; rs2D = s2; isbranchtakenE = br;
    memreadM = mrm; memwriteM = mwm; dmem_ready = rdy; halt_req = hr; step_req = sr;
  endtask

  task automatic idle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Called at posedge+1: checks settled outputs at posedge+2, then advances.
  task automatic cyc(input string tag);
    logic [6:0] e;
    #1;
    e = model_comb();
    check({tag, ":ctl"}, {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, killW}, {25'd0, e});
    check({tag, ":halted"}, {31'd0, halted}, {31'd0, m_frozen});
    check({tag, ":trap"}, {31'd0, mem_timeout}, {31'd0, m_trap});
    check({tag, ":cnt"}, {28'd0, stall_count}, m_cnt);
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    @(posedge clk); #1;
    model_reset();

    // Reset state
    cyc("reset");
    idle();
    cyc("idle0");

    // Load-use: one bubble, then rdE=0 gives no stall
    set_in(1, 1, 5, 5, 0, 0, 0, 0, 1, 0, 0); cyc("loaduse");
    idle();                                   cyc("lu_after");
    check("lu_count", {28'd0, stall_count}, 32'd1);
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("lu_rd0");
    set_in(1, 1, 7, 3, 7, 0, 0, 0, 1, 0, 0); cyc("loaduse_rs2");
    check("lu_count2", {28'd0, stall_count}, 32'd2);

    // Branch over load-use
    set_in(1, 1, 5, 5, 0, 1, 0, 0, 1, 0, 0); cyc("br_lu");
    idle();                                   cyc("br_after");

    // Memory wait: 3 low cycles then ready
    repeat (3) begin set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("memwait"); end
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0); cyc("mem_ready");
    idle();                                   cyc("mem_after");
    check("mw_count", {28'd0, stall_count}, 32'd5);

    // Halt / step / release
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cyc("halt_req");
    check("halt_rise", {31'd0, halted}, 32'd1);
    cyc("halted");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cyc("step_req");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cyc("step");
    cyc("rehalt");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("release");
    cyc("run_again");

    // Timeout trap: 4 frozen cycles, then only reset leaves HALTED
    repeat (MT) begin set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cyc("to_wait"); end
    check("to_flag", {31'd0, mem_timeout}, 32'd1);
    check("to_halted", {31'd0, halted}, 32'd1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); cyc("to_step");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("to_rel"); cyc("to_rel2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("to_reset");
    idle();                                   cyc("to_clear");
    check("to_cnt0", {28'd0, stall_count}, 32'd0);

    // Reset mid-wait
    repeat (2) begin set_in(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("rmw_wait"); end
    set_in(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("rmw_rst");
    idle(); cyc("rmw_idle"); cyc("rmw_idle2");

    // Counter saturation during a long halt
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (CNT_SAT + 5) cyc("sat");
    check("sat_cnt", {28'd0, stall_count}, CNT_SAT);
    idle(); cyc("sat_rel"); cyc("sat_idle");

    // Randomized traffic
    begin
      logic hr;
      hr = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) hr = ~hr;
        set_in($urandom_range(63) != 0,
               $urandom_range(1) == 1,
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
               $urandom_range(5) == 0,
               $urandom_range(3) == 0,
               $urandom_range(5) == 0,
               $urandom_range(3) != 0,
               hr,
               $urandom_range(7) == 0);
        cyc("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
